// File: rtl/mmap_rx_port.sv
// mmap_rx_port
//   Memory-mapped receive port. An external byte source pushes bytes into a
//   small FIFO, and the CPU drains them through the device bus.
//   The port also provides status bits, sticky overflow tracking and a level
//   interrupt.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : source presents a byte
//   in_data    : byte from source
//   in_ready   : FIFO can accept a byte (registered full, inverted)
//   mmap_re    : CPU read strobe
//   mmap_we    : CPU write strobe
//   mmap_addr  : byte offset; [3:2] selects DATA/STATUS/CTRL/reserved
//   mmap_wd    : CPU write data
//   mmap_rd    : CPU read data, combinational, 0 when mmap_re is low
//   irq        : level interrupt = ie && non-empty

module mmap_rx_port #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        mmap_re,
    input  logic        mmap_we,
    input  logic [3:0]  mmap_addr,
    input  logic [31:0] mmap_wd,
    output logic [31:0] mmap_rd,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          ie_q, ie_d;

    logic [1:0] sel;
    logic       empty, full;
    logic       push, pop, flush, ovf_clr, ovf_set, ctrl_wr;
    logic       unused_bits;

    assign sel   = mmap_addr[3:2];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    assign unused_bits = ^{mmap_addr[1:0], mmap_wd[31:3]};

    assign ctrl_wr = mmap_we && (sel == A_CTRL);
    assign flush   = ctrl_wr && mmap_wd[2];
    assign ovf_clr = ctrl_wr && mmap_wd[1];

    // in_ready only looks at registered state, so a same-cycle pop never
    // rescues a byte offered while full.
    assign push    = in_valid && !full && !flush;
    assign ovf_set = in_valid && full;

    // A simultaneous write suppresses the pop; an empty FIFO never pops,
    // even if a push lands in the same cycle.
    assign pop = mmap_re && !mmap_we && (sel == A_DATA) && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ie_d     = ie_q;
        ovf_d    = ovf_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end

        if (ctrl_wr) ie_d = mmap_wd[0];

        // Set wins over a same-cycle clear.
        if (ovf_set)      ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ie_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ie_q     <= ie_d;
        end
    end

    // Storage has no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    always_comb begin
        mmap_rd = '0;
        if (mmap_re) begin
            unique case (sel)
                A_DATA:   mmap_rd = empty ? 32'h0 : {24'h0, mem_q[rd_ptr_q]};
                A_STATUS: mmap_rd = {16'h0, 8'(count_q), 5'h0, ovf_q, full, !empty};
                A_CTRL:   mmap_rd = {31'h0, ie_q};
                default:  mmap_rd = '0;
            endcase
        end
    end

    assign in_ready = !full;
    assign irq      = ie_q && !empty;

endmodule

// File: tb/tb_mmap_rx_port.sv
module tb_mmap_rx_port;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mmap_re;
    logic        mmap_we;
    logic [3:0]  mmap_addr;
    logic [31:0] mmap_wd;
    logic [31:0] mmap_rd;
    logic        irq;

    mmap_rx_port #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mmap_re   (mmap_re),
        .mmap_we   (mmap_we),
        .mmap_addr (mmap_addr),
        .mmap_wd   (mmap_wd),
        .mmap_rd   (mmap_rd),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: byte queue plus the two control/status flags.
    logic [7:0] m_q[$];
    bit         m_ovf;
    bit         m_ie;
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input bit re, input logic [3:0] a);
        int n;
        n = m_q.size();
        if (!re) return 32'h0;
        case (a[3:2])
            2'd0:    return (n > 0) ? {24'h0, m_q[0]} : 32'h0;
            2'd1:    return (n << 8) | (m_ovf ? 4 : 0) | ((n == DEPTH) ? 2 : 0) | ((n > 0) ? 1 : 0);
            2'd2:    return {31'h0, m_ie};
            default: return 32'h0;
        endcase
    endfunction

    // One bus/source cycle: drive, check outputs mid-cycle, clock, update model.
    task automatic step(input bit v, input logic [7:0] d, input bit re, input bit we,
                        input logic [3:0] a, input logic [31:0] wd);
        bit full, flush, do_pop, do_push;
        in_valid  = v;
        in_data   = d;
        mmap_re   = re;
        mmap_we   = we;
        mmap_addr = a;
        mmap_wd   = wd;
        #2;
        full = (m_q.size() == DEPTH);
        last_rd = mmap_rd;
        chk("in_ready", {31'h0, in_ready}, {31'h0, !full});
        chk("irq", {31'h0, irq}, {31'h0, m_ie && m_q.size() > 0});
        chk("mmap_rd", mmap_rd, model_rd(re, a));
        @(posedge clk);
        flush   = we && a[3:2] == 2'd2 && wd[2];
        do_pop  = re && !we && a[3:2] == 2'd0 && m_q.size() > 0;
        do_push = v && !full;
        if (flush) m_q.delete();
        else begin
            if (do_pop)  void'(m_q.pop_front());
            if (do_push) m_q.push_back(d);
        end
        if (we && a[3:2] == 2'd2) begin
            m_ie = wd[0];
            if (wd[1]) m_ovf = 0;
        end
        if (v && full) m_ovf = 1;
        #1;
        in_valid = 0;
        mmap_re  = 0;
        mmap_we  = 0;
    endtask

    task automatic push(input logic [7:0] d);
        step(1, d, 0, 0, 4'h0, 32'h0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(0, 8'h0, 1, 0, a, 32'h0);
    endtask

    initial begin
        // Reset with in_valid high.
        rst_n = 0; in_valid = 1; in_data = 8'hAA; mmap_re = 1; mmap_we = 0;
        mmap_addr = 4'h4; mmap_wd = 0;
        m_ovf = 0; m_ie = 0;
        #2;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_rd", mmap_rd, 32'h0);
        #20;
        in_valid = 0; mmap_re = 0;
        rst_n = 1;
        @(posedge clk); #1;
        rd(4'h4);
        chk("rst_status", last_rd, 32'h0);

        // Ordered stream.
        push(8'h41); push(8'h42); push(8'h43);
        rd(4'h4); chk("stream_cnt3", last_rd, 32'h0301);
        rd(4'h0); chk("stream_b0", last_rd, 32'h41);
        rd(4'h0); chk("stream_b1", last_rd, 32'h42);
        rd(4'h0); chk("stream_b2", last_rd, 32'h43);
        rd(4'h0); chk("stream_empty", last_rd, 32'h0);
        rd(4'h4); chk("stream_cnt0", last_rd, 32'h0);

        // Fill, overflow, drain, clear.
        for (int i = 0; i < 16; i++) push(8'(i));
        rd(4'h4); chk("full_status", last_rd, 32'h1003);
        chk("full_ready", {31'h0, in_ready}, 32'h0);
        push(8'hFF);
        rd(4'h4); chk("ovf_status", last_rd, 32'h1007);
        // Offer while full with a same-cycle pop: still dropped.
        step(1, 8'hEE, 1, 0, 4'h0, 32'h0); chk("full_pop_b0", last_rd, 32'h00);
        for (int i = 1; i < 16; i++) begin
            rd(4'h0); chk("drain", last_rd, 32'(i));
        end
        rd(4'h0); chk("drain_empty", last_rd, 32'h0);
        step(0, 8'h0, 0, 1, 4'h8, 32'h2);
        rd(4'h4); chk("ovf_clr", last_rd, 32'h0);

        // Push into empty with same-cycle DATA read: read 0, byte kept.
        step(1, 8'h3C, 1, 0, 4'h0, 32'h0); chk("push_empty_rd", last_rd, 32'h0);
        rd(4'h0); chk("push_empty_kept", last_rd, 32'h3C);

        // Wrap-around with simultaneous push/pop at count 5.
        for (int i = 0; i < 5; i++) push(8'h80 + 8'(i));
        for (int i = 0; i < 40; i++) begin
            step(1, 8'h85 + 8'(i), 1, 0, 4'h0, 32'h0);
            chk("wrap_order", last_rd, 32'h80 + 32'(i));
        end
        rd(4'h4); chk("wrap_cnt5", last_rd, 32'h0501);
        for (int i = 0; i < 5; i++) rd(4'h0);

        // Interrupt and flush.
        step(0, 8'h0, 0, 1, 4'h8, 32'h1);
        push(8'h55);
        rd(4'h8); chk("irq_on", {31'h0, irq}, 32'h1); chk("ctrl_ie", last_rd, 32'h1);
        step(1, 8'h66, 0, 1, 4'h8, 32'h5);
        rd(4'h4); chk("flush_cnt", last_rd, 32'h0); chk("flush_irq", {31'h0, irq}, 32'h0);

        // Read+write in the same cycle: no pop, rd reflects register.
        push(8'h11);
        step(0, 8'h0, 1, 1, 4'h0, 32'h0); chk("rw_rd", last_rd, 32'h11);
        rd(4'h4); chk("rw_nopop", last_rd, 32'h0101);

        // Overflow clear and set in the same cycle: set wins.
        for (int i = 0; i < 15; i++) push(8'(i));
        step(1, 8'h99, 0, 1, 4'h8, 32'h3);
        rd(4'h4); chk("ovf_setwins", last_rd, 32'h1007);
        step(0, 8'h0, 0, 1, 4'h8, 32'h5);
        rd(4'h4); chk("flush_keeps_ovf", last_rd, 32'h0004);
        step(0, 8'h0, 0, 1, 4'h8, 32'h3);

        // Async reset mid-stream with 7 bytes queued.
        for (int i = 0; i < 7; i++) push(8'hA0 + 8'(i));
        rd(4'h4); chk("pre_rst", last_rd, 32'h0701);
        #2;
        rst_n = 0;
        #1;
        chk("arst_ready", {31'h0, in_ready}, 32'h1);
        chk("arst_irq", {31'h0, irq}, 32'h0);
        mmap_re = 1; mmap_addr = 4'h4;
        #1;
        chk("arst_status", mmap_rd, 32'h0);
        mmap_re = 0;
        m_q.delete(); m_ovf = 0; m_ie = 0;
        #1;
        rst_n = 1;
        @(posedge clk); #1;
        rd(4'h4); chk("post_rst", last_rd, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit v, re, we;
            logic [3:0] a;
            logic [31:0] wd;
            v  = ($urandom_range(0, 99) < 55);
            re = ($urandom_range(0, 99) < 50);
            we = ($urandom_range(0, 99) < 8);
            a  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            wd = {$urandom} & 32'hFFFF_FFF3;
            wd[0] = $urandom_range(0, 1);
            wd[1] = ($urandom_range(0, 3) == 0);
            wd[2] = ($urandom_range(0, 7) == 0);
            step(v, 8'($urandom), re, we, a, wd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
